led_source_scheduler: RTL
=========================

Name: led_source_scheduler

Overview:
Shares the 8-digit seven-segment display between four requesters, such as the syscall print value, the PC, the cycle counter and halt status. Each requester writes a 32-bit shadow register through a round-robin request/grant handshake. A small FSM chooses which shadow register is shown, advancing on a button pulse or an auto-rotate timer. The registered LedData output feeds the existing display driver (divider/counter/decoder/pattern chain).

Parameters:
DWELL, 50000000, auto-rotate period in CLK cycles (≥2)
LOCK, 1000, post-switch lockout in CLK cycles (≥1)

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
req  in  4  req[i]=1: requester i wants to load data_i
data0  in  32  requester 0 value
data1  in  32  requester 1 value
data2  in  32  requester 2 value
data3  in  32  requester 3 value
btn_next  in  1  single-cycle pulse (pre-debounced): show next source
auto_en  in  1  level: enable timed rotation
freeze  in  1  level: hold LedData at its current value
grant  out  4  one-hot, one-cycle pulse: the write of data_i completed
LedData  out  32  value to display
src_id  out  2  index of displayed source
dirty  out  4  dirty[i]=1: shadow i changed since last shown

Behaviour:
- Reset (async, RST_N=0): shadow0..3=0, grant=0, LedData=0, src_id=0, dirty=0, rr_ptr=0, dwell_cnt=0, lock_cnt=0, state=S_SHOW. Reset during any activity aborts it, with no partial writes.
- Arbiter, each edge:
  - Eligible = req & ~grant. The currently granted requester is excluded for one cycle.
  - If eligible≠0: pick the first set bit scanning rr_ptr, rr_ptr+1, … (mod 4). Set grant to one-hot(k), load shadow[k]<=data_k, and set rr_ptr<=k+1 mod 4.
  - Else: grant<=0, rr_ptr unchanged.
  - At most one write per cycle.
- Requester handshake: hold req and data stable until grant[i] is seen high. Drop req at the edge that ends the grant cycle. A requester that keeps req high is re-granted no sooner than 2 cycles later.
- LedData, each edge when freeze=0: LedData<=shadow[src_id] using the registered values. When freeze=1, LedData holds.
- Latency: data_i captured at edge N appears on LedData at edge N+1 if i==src_id and freeze=0. A src_id change at edge N shows on LedData at edge N+1.
- dirty[i]:
  - Set at the edge where shadow i is written, unless i==src_id and freeze=0.
  - Cleared while i==src_id and freeze=0.
  - Set has priority when freeze=1.
- FSM S_SHOW:
  - dwell_cnt increments while auto_en=1 and clears to 0 when auto_en=0.
  - Advance when btn_next=1, or when auto_en=1 and dwell_cnt==DWELL-1. A simultaneous button and timeout advance only once.
  - Advance means: src_id<=src_id+1 (3 wraps to 0), dwell_cnt<=0, lock_cnt<=0, go to S_LOCK.
- FSM S_LOCK:
  - btn_next is ignored and dwell_cnt is held at 0.
  - lock_cnt increments. At lock_cnt==LOCK-1, go to S_SHOW.
- Shadow writes and the arbiter run independently of FSM state and freeze.

Test Plan:
- Reset, then req=4'b0001 with data0=32'h12345678 held until grant: grant=4'b0001 on cycle 1, LedData=32'h12345678 one cycle later, dirty=0.
- req=4'b1111 held continuously from reset: grants rotate 0001→0010→0100→1000→0001, never the same bit twice in a row. Shadows load data0..3 in that order; dirty=4'b1110 after the first round.
- btn_next pulse: src_id 0→1, LedData=shadow1 next cycle, dirty[1] cleared. Another btn_next within LOCK cycles leaves src_id=1; one after LOCK cycles gives src_id=2. Four presses wrap back to 0.
- auto_en=1 with DWELL=8, LOCK=2: src_id advances at 8-cycle dwell plus 2-cycle lock intervals. Dropping auto_en mid-count resets dwell_cnt, so re-enabling waits a full DWELL.
- freeze=1 then write displayed source 0 with 32'hDEADBEEF: LedData unchanged and dirty[0]=1. Releasing freeze gives LedData=32'hDEADBEEF next cycle and dirty[0]=0.
- Assert RST_N=0 asynchronously mid-grant and in S_LOCK with src_id=2: all outputs 0 immediately. After release, btn_next gives src_id=1.

Source files
------------

// File: rtl/led_source_scheduler.sv
// Shares one 32-bit seven-segment display between four requesters. Writes into
// per-source shadow registers go through a round-robin arbiter. A show/lockout FSM picks the displayed source.
module led_source_scheduler #(
    parameter int unsigned DWELL = 50000000,
    parameter int unsigned LOCK  = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] data3,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        freeze,
    output logic [3:0]  grant,
    output logic [31:0] LedData,
    output logic [1:0]  src_id,
    output logic [3:0]  dirty
);

    localparam int DW_W = $clog2(DWELL + 1);
    localparam int LK_W = $clog2(LOCK + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [LK_W-1:0] LOCK_LAST  = LK_W'(LOCK - 1);

    typedef enum logic {S_SHOW, S_LOCK} state_t;

    state_t            state_q, state_d;
    logic [31:0]       shadow_q [4];
    logic [31:0]       shadow_d [4];
    logic [31:0]       data_in  [4];
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [31:0]       led_data_q, led_data_d;
    logic [1:0]        src_id_q, src_id_d;
    logic [3:0]        dirty_q, dirty_d;
    logic [DW_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [LK_W-1:0]   lock_cnt_q, lock_cnt_d;

    logic [3:0]        eligible;
    logic              win_valid;
    logic [1:0]        win_idx;
    logic [1:0]        cand;

    always_comb begin
        data_in[0] = data0;
        data_in[1] = data1;
        data_in[2] = data2;
        data_in[3] = data3;
    end

    // Round-robin pick; the requester granted last cycle sits out one cycle
    // so a held req cannot monopolise the write port.
    always_comb begin
        eligible  = req & ~grant_q;
        win_valid = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = '0;
        for (int j = 0; j < 4; j++) begin
            cand = rr_ptr_q + 2'(j);
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_d  = 4'b0000;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (win_valid) begin
            grant_d           = 4'b0001 << win_idx;
            shadow_d[win_idx] = data_in[win_idx];
            rr_ptr_d          = win_idx + 2'd1;
        end
    end

    always_comb begin
        led_data_d = freeze ? led_data_q : shadow_q[src_id_q];
        dirty_d    = dirty_q;
        for (int i = 0; i < 4; i++) begin
            if ((src_id_q == 2'(i)) && !freeze) begin
                dirty_d[i] = 1'b0;
            end else if (win_valid && (win_idx == 2'(i))) begin
                dirty_d[i] = 1'b1;
            end
        end
    end

    // Source selection: dwell in S_SHOW, then a lockout that swallows
    // button bounce after every switch.
    always_comb begin
        state_d     = state_q;
        src_id_d    = src_id_q;
        dwell_cnt_d = dwell_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        case (state_q)
            S_SHOW: begin
                dwell_cnt_d = auto_en ? dwell_cnt_q + 1'b1 : '0;
                if (btn_next || (auto_en && (dwell_cnt_q == DWELL_LAST))) begin
                    src_id_d    = src_id_q + 2'd1;
                    dwell_cnt_d = '0;
                    lock_cnt_d  = '0;
                    state_d     = S_LOCK;
                end
            end
            S_LOCK: begin
                dwell_cnt_d = '0;
                lock_cnt_d  = lock_cnt_q + 1'b1;
                if (lock_cnt_q == LOCK_LAST) begin
                    lock_cnt_d = '0;
                    state_d    = S_SHOW;
                end
            end
            default: state_d = S_SHOW;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_SHOW;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            led_data_q  <= '0;
            src_id_q    <= '0;
            dirty_q     <= '0;
            dwell_cnt_q <= '0;
            lock_cnt_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            led_data_q  <= led_data_d;
            src_id_q    <= src_id_d;
            dirty_q     <= dirty_d;
            dwell_cnt_q <= dwell_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign grant   = grant_q;
    assign LedData = led_data_q;
    assign src_id  = src_id_q;
    assign dirty   = dirty_q;

endmodule
